// File: rtl/cond_pkg.sv
// Shared types for the Execute-stage conditional-execution unit.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE, CS, CC, MI, PL, VS, VC,
    HI, LS, GE, LT, GT, LE, AL, NV
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    cond_t      cond;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] flag_w;
    logic [1:0] alu_ctl;
  } ctl_e_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator: cond field vs {N,Z,C,V}.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_t'(cond_i))
      EQ: cond_ex_o = z;
      NE: cond_ex_o = ~z;
      CS: cond_ex_o = c;
      CC: cond_ex_o = ~c;
      MI: cond_ex_o = n;
      PL: cond_ex_o = ~n;
      VS: cond_ex_o = v;
      VC: cond_ex_o = ~v;
      HI: cond_ex_o = c & ~z;
      LS: cond_ex_o = ~c | z;
      GE: cond_ex_o = (n == v);
      LT: cond_ex_o = (n != v);
      GT: cond_ex_o = ~z & (n == v);
      LE: cond_ex_o = z | (n != v);
      AL: cond_ex_o = 1'b1;
      NV: cond_ex_o = 1'b0;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage register, NZCV flag register and condition gating of
// every state-changing write so failed instructions retire as no-ops.
module cond_unit
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       n_reset,
  input  logic       stall_e,
  input  logic       flush_e,
  input  logic [3:0] cond_d,
  input  logic       pcs_d,
  input  logic       reg_w_d,
  input  logic       mem_w_d,
  input  logic       mem_to_reg_d,
  input  logic       alu_src_d,
  input  logic [1:0] flag_w_d,
  input  logic [1:0] alu_ctl_d,
  input  logic [3:0] alu_flags,
  output logic       pcs_e,
  output logic       reg_w_e,
  output logic       mem_w_e,
  output logic       mem_to_reg_e,
  output logic       alu_src_e,
  output logic [1:0] alu_ctl_e,
  output logic       cond_ex_e,
  output logic [3:0] flags
);

  ctl_e_t     ctl_q, ctl_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex;

  cond_check u_check (
    .cond_i    (ctl_q.cond),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex)
  );

  // Flush beats stall so a squashed instruction cannot linger in Execute.
  always_comb begin
    ctl_d = ctl_q;
    if (flush_e) begin
      ctl_d = '0;
    end else if (!stall_e) begin
      ctl_d.cond       = cond_t'(cond_d);
      ctl_d.pcs        = pcs_d;
      ctl_d.reg_w      = reg_w_d;
      ctl_d.mem_w      = mem_w_d;
      ctl_d.mem_to_reg = mem_to_reg_d;
      ctl_d.alu_src    = alu_src_d;
      ctl_d.flag_w     = flag_w_d;
      ctl_d.alu_ctl    = alu_ctl_d;
    end
  end

  // Flags retire once, on the non-stalled edge; N/Z and C/V are independent.
  always_comb begin
    flags_d = flags_q;
    if (!stall_e && cond_ex) begin
      if (ctl_q.flag_w[1]) flags_d[FLAG_N:FLAG_Z] = alu_flags[FLAG_N:FLAG_Z];
      if (ctl_q.flag_w[0]) flags_d[FLAG_C:FLAG_V] = alu_flags[FLAG_C:FLAG_V];
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ctl_q   <= '0;
      flags_q <= '0;
    end else begin
      ctl_q   <= ctl_d;
      flags_q <= flags_d;
    end
  end

  assign cond_ex_e    = cond_ex;
  assign pcs_e        = ctl_q.pcs   & cond_ex;
  assign reg_w_e      = ctl_q.reg_w & cond_ex;
  assign mem_w_e      = ctl_q.mem_w & cond_ex;
  assign mem_to_reg_e = ctl_q.mem_to_reg;
  assign alu_src_e    = ctl_q.alu_src;
  assign alu_ctl_e    = ctl_q.alu_ctl;
  assign flags        = flags_q;

endmodule
